// File: rtl/ble_ahb_pkg.sv
// BLE PHY AHB slave shared types.
// Bus encodings and slave FSM state enum.
package ble_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_STALL,
    ST_RD_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ble_ahb_slave_if.sv
// AHB-Lite slave front-end for the BLE PHY register file.
// BLE_AHB_ERR_RESP_EN: two-cycle ERROR response on illegal transfers.
module ble_ahb_slave_if
  import ble_ahb_pkg::*;
#(
  parameter int AD     = 2,
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [WIDTH-1:0]  HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [WIDTH-1:0]  HRDATA,
  output logic              rf_write_en,
  output logic              rf_read_en,
  output logic [AD-1:0]     rf_address,
  output logic [WIDTH-1:0]  rf_wdata,
  input  logic [WIDTH-1:0]  rf_rdata
);

  localparam logic [AD:0] DEPTH_W = (AD+1)'(DEPTH);

  state_e        state;
  state_e        state_nx;
  logic [AD-1:0] lat_addr;
  logic [AD-1:0] lat_nx;
  logic [AD-1:0] idx;
  logic          accept;
  logic          valid;
  logic          illegal;

  assign idx = HADDR[AD+1:2];

  assign accept = (state != ST_RD_STALL)
               && (state != ST_ERR1);

  assign valid = HSEL && HREADY && accept
              && ((HTRANS == HTRANS_NONSEQ)
               || (HTRANS == HTRANS_SEQ));

  assign illegal = (HSIZE != SIZE_WORD)
                || (HADDR[1:0] != 2'b00)
                || (HADDR[ADDR_W-1:AD+2] != '0)
                || ({1'b0, idx} >= DEPTH_W);

  assign rf_wdata = HWDATA;
  assign HRDATA   = (state == ST_RD_DATA) ? rf_rdata : '0;

`ifdef BLE_AHB_ERR_RESP_EN
  assign HREADYOUT = (state != ST_RD_STALL)
                  && (state != ST_ERR1);
  assign HRESP = ((state == ST_ERR1) || (state == ST_ERR2))
               ? HRESP_ERROR : HRESP_OKAY;
`else
  assign HREADYOUT = (state != ST_RD_STALL);
  assign HRESP     = HRESP_OKAY;
`endif

  // Decode address phase into strobes and next state.
  always_comb begin
    state_nx    = ST_IDLE;
    lat_nx      = lat_addr;
    rf_write_en = 1'b0;
    rf_read_en  = 1'b0;
    rf_address  = idx;
    if (state == ST_RD_STALL) begin
      rf_read_en = 1'b1;
      rf_address = lat_addr;
      state_nx   = ST_RD_DATA;
    end
`ifdef BLE_AHB_ERR_RESP_EN
    else if (state == ST_ERR1) begin
      state_nx = ST_ERR2;
    end
`endif
    else if (valid) begin
      if (illegal) begin
`ifdef BLE_AHB_ERR_RESP_EN
        state_nx = ST_ERR1;
`else
        state_nx = ST_IDLE;
`endif
      end else if (HWRITE) begin
        rf_write_en = 1'b1;
        state_nx    = ST_WR_DATA;
      end else if (state == ST_WR_DATA) begin
        lat_nx   = idx;
        state_nx = ST_RD_STALL;
      end else begin
        rf_read_en = 1'b1;
        state_nx   = ST_RD_DATA;
      end
    end
  end

  // State and stalled-read address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      lat_addr <= '0;
    end else begin
      state    <= state_nx;
      lat_addr <= lat_nx;
    end
  end

endmodule

// File: tb/tb_ble_ahb_slave_if.sv
// Directed bench for ble_ahb_slave_if.
// Register file model plus read-data scoreboard.
module tb_ble_ahb_slave_if;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [2:0] SZ_WORD  = 3'b010;
  localparam logic [2:0] SZ_BYTE  = 3'b000;

  logic        clk;
  logic        reset;
  logic        HSEL;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        rf_write_en;
  logic        rf_read_en;
  logic [1:0]  rf_address;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem [4];
  logic        wr_pend;
  logic [1:0]  wr_addr;

  assign HREADY = HREADYOUT;

  ble_ahb_slave_if dut (
    .clk        (clk),
    .reset      (reset),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .rf_write_en(rf_write_en),
    .rf_read_en (rf_read_en),
    .rf_address (rf_address),
    .rf_wdata   (rf_wdata),
    .rf_rdata   (rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    mem[2] = 32'h0;
    mem[3] = 32'h007E_10A8;
    wr_pend  = 1'b0;
    wr_addr  = 2'd0;
    rf_rdata = 32'h0;
  end

  // Register file: data-phase write, registered read, drops read on pending write.
  always @(posedge clk) begin
    wr_pend <= rf_write_en;
    wr_addr <= rf_address;
    if (wr_pend)
      mem[wr_addr] <= rf_wdata;
    if (rf_read_en)
      rf_rdata <= wr_pend ? 32'hDEAD_DEAD : mem[rf_address];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic        sel,
                      input logic [1:0]  tr,
                      input logic        wr,
                      input logic [11:0] a,
                      input logic [2:0]  sz,
                      input logic [31:0] wd);
    @(posedge clk);
    #1;
    HSEL   = sel;
    HTRANS = tr;
    HWRITE = wr;
    HADDR  = a;
    HSIZE  = sz;
    HWDATA = wd;
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] wd);
    step(1'b0, T_IDLE, 1'b0, 12'h000, SZ_WORD, wd);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd);
    step(1'b1, T_NONSEQ, 1'b1, a, SZ_WORD, wd);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] wd);
    step(1'b1, T_NONSEQ, 1'b0, a, SZ_WORD, wd);
  endtask

  task automatic rd_done(input string tag, input int expw);
    int w = 0;
    logic [31:0] e;
    while (HREADYOUT !== 1'b1 && w < 4) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready"}, 32'(HREADYOUT), 32'd1);
    chk({tag, "_waits"}, 32'(w), 32'(expw));
    chk({tag, "_resp"}, 32'(HRESP), 32'd0);
    chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, HRDATA, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    HSEL   = 1'b0;
    HTRANS = T_IDLE;
    HWRITE = 1'b0;
    HADDR  = 12'h000;
    HSIZE  = SZ_WORD;
    HWDATA = 32'h0;
    @(negedge clk);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_wen", 32'(rf_write_en), 32'd0);
    chk("rst_ren", 32'(rf_read_en), 32'd0);
    chk("rst_addr", 32'(rf_address), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    rd(12'h00C, 32'h0);
    exp_q.push_back(32'h007E_10A8);
    chk("r3_ren", 32'(rf_read_en), 32'd1);
    chk("r3_addr", 32'(rf_address), 32'd3);
    idle(32'h0);
    rd_done("r3", 0);

    wr(12'h000, 32'h0);
    chk("w0_wen", 32'(rf_write_en), 32'd1);
    chk("w0_addr", 32'(rf_address), 32'd0);
    idle(32'h0000_0007);
    chk("w0_wdata", rf_wdata, 32'h7);
    chk("w0_wen_off", 32'(rf_write_en), 32'd0);
    chk("w0_ready", 32'(HREADYOUT), 32'd1);
    idle(32'h0);
    rd(12'h000, 32'h0);
    exp_q.push_back(32'h7);
    chk("r0_ren", 32'(rf_read_en), 32'd1);
    idle(32'h0);
    rd_done("r0", 0);

    wr(12'h004, 32'h0);
    rd(12'h004, 32'h3);
    exp_q.push_back(32'h3);
    chk("raw_ren_off", 32'(rf_read_en), 32'd0);
    chk("raw_wready", 32'(HREADYOUT), 32'd1);
    idle(32'h0);
    chk("raw_stall", 32'(HREADYOUT), 32'd0);
    chk("raw_stall_ren", 32'(rf_read_en), 32'd1);
    chk("raw_stall_addr", 32'(rf_address), 32'd1);
    rd_done("raw", 1);

    step(1'b1, T_NONSEQ, 1'b1, 12'h008, SZ_BYTE, 32'h0);
    chk("bw_wen", 32'(rf_write_en), 32'd0);
    idle(32'h0000_00FF);
`ifdef BLE_AHB_ERR_RESP_EN
    chk("bw_err1_ready", 32'(HREADYOUT), 32'd0);
    chk("bw_err1_resp", 32'(HRESP), 32'd1);
    @(negedge clk);
    chk("bw_err2_ready", 32'(HREADYOUT), 32'd1);
    chk("bw_err2_resp", 32'(HRESP), 32'd1);
    idle(32'h0);
`else
    chk("bw_ready", 32'(HREADYOUT), 32'd1);
    chk("bw_resp", 32'(HRESP), 32'd0);
`endif
    chk("bw_wen2", 32'(rf_write_en), 32'd0);

    rd(12'h010, 32'h0);
    chk("oor_ren", 32'(rf_read_en), 32'd0);
`ifdef BLE_AHB_ERR_RESP_EN
    idle(32'h0);
    chk("oor_err1_ready", 32'(HREADYOUT), 32'd0);
    chk("oor_err1_resp", 32'(HRESP), 32'd1);
    rd(12'h000, 32'h0);
    chk("oor_err2_ready", 32'(HREADYOUT), 32'd1);
    chk("oor_err2_resp", 32'(HRESP), 32'd1);
`else
    rd(12'h000, 32'h0);
    chk("oor_ready", 32'(HREADYOUT), 32'd1);
    chk("oor_resp", 32'(HRESP), 32'd0);
`endif
    chk("oor_hrdata", HRDATA, 32'd0);
    chk("oor_next_ren", 32'(rf_read_en), 32'd1);
    exp_q.push_back(32'h7);
    idle(32'h0);
    rd_done("oor_next", 0);

    wr(12'h000, 32'h0);
    wr(12'h004, 32'h0000_000A);
    chk("waw_ready", 32'(HREADYOUT), 32'd1);
    chk("waw_wen", 32'(rf_write_en), 32'd1);
    rd(12'h004, 32'h0000_000B);
    exp_q.push_back(32'hB);
    chk("waw_rd_ren_off", 32'(rf_read_en), 32'd0);
    idle(32'h0);
    rd_done("waw_rd", 1);

    rd(12'h000, 32'h0);
    exp_q.push_back(32'hA);
    wr(12'h008, 32'h0);
    chk("war_wen", 32'(rf_write_en), 32'd1);
    rd_done("war", 0);
    idle(32'h0000_0055);

    wr(12'h008, 32'h0);
    rd(12'h008, 32'h0000_0066);
    idle(32'h0);
    chk("rs_stall", 32'(HREADYOUT), 32'd0);
    reset = 1'b0;
    #1;
    chk("rs_ready", 32'(HREADYOUT), 32'd1);
    chk("rs_resp", 32'(HRESP), 32'd0);
    chk("rs_hrdata", HRDATA, 32'd0);
    chk("rs_ren", 32'(rf_read_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd(12'h008, 32'h0);
    exp_q.push_back(32'h66);
    idle(32'h0);
    rd_done("rs_rd", 0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
